sdrc_app_arbiter: RTL and testbench
===================================

// Module: sdrc_app_arbiter
// PURPOSE
//  Two-master arbiter and sequencer in front of the SDRAM controller application port.
//  Selects one requester with round-robin priority and forwards its address, length and direction.
//  Holds the grant for the whole burst. Steers wr_next, rd_valid and read data back to the owner until the burst's last beat.
//  Sits between system masters and the width converter, so every burst reaches the 8/16/32-bit path intact.
// PARAMETERS
//  APP_AW  26  application address width
//  APP_DW  32  application data width
//  LEN_W   9   burst length width, in application words
// PORTS
//  clk              in   1       controller clock; all logic on posedge
//  reset_n          in   1       asynchronous active-low reset
//  mN_req (N=0,1)   in   1       master N burst request; held until mN_ack
//  mN_addr          in   APP_AW  master N start address
//  mN_len           in   LEN_W   master N burst length in words
//  mN_wr_n          in   1       0=write, 1=read
//  mN_wr_data       in   APP_DW  master N write data
//  mN_ack           out  1       one-cycle pulse when request accepted
//  mN_wr_next       out  1       master N advances write data
//  mN_rd_valid      out  1       master N read data valid
//  mN_done          out  1       one-cycle pulse on last beat of master N burst
//  app_req          out  1       request to controller
//  app_req_addr     out  APP_AW  latched address
//  app_req_len      out  LEN_W   latched length
//  app_req_wr_n     out  1       latched direction
//  app_req_ack      in   1       controller accepted request
//  app_wr_data      out  APP_DW  write data from granted master
//  app_wr_next      in   1       controller consumed write word
//  app_last_wr      in   1       last write beat
//  app_rd_valid     in   1       read word valid
//  app_last_rd      in   1       last read beat
//  app_rd_data      in   APP_DW  read data; broadcast to both masters
//  grant            out  2       one-hot owner; 00 when idle
//  len_err          out  1       one-cycle pulse on length/beat mismatch
// BEHAVIOUR
//  Reset: every output 0; FSM=IDLE; rr_ptr=0 (m0 preferred); beat counter 0.
//  - Reset is asynchronous at any time, including mid-burst: the burst is abandoned and no mN_done is issued.
//  FSM IDLE -> REQ -> XFER -> IDLE.
//  IDLE:
//  - Sample mN_req. With exactly one request, that master wins. With both, the master indicated by rr_ptr wins.
//  - Latch the winner's addr/len/wr_n, set grant, load beat_cnt=len, go to REQ.
//  - Latency: request first seen at cycle T gives app_req=1 at T+1.
//  - len==0: no request is forwarded. mN_ack and len_err pulse at T+1, the FSM stays in IDLE, and rr_ptr toggles.
//  REQ:
//  - app_req=1 with registered addr/len/wr_n, held stable until app_req_ack.
//  - On ack: mN_ack pulses in the next cycle, app_req drops in the next cycle, go to XFER.
//  - Requests from the other master stay pending and are not acked.
//  XFER:
//  - app_wr_data = granted master's mN_wr_data, combinational mux.
//  - app_wr_next -> mN_wr_next and app_rd_valid -> mN_rd_valid of the owner only; the non-owner sees 0.
//  - beat_cnt decrements once per wr_next (write) or rd_valid (read); it saturates at 0 and never wraps.
//  - On app_last_wr (write) or app_last_rd (read): go to IDLE, clear grant, mN_done pulses.
//    - rr_ptr points to the other master.
//    - len_err pulses if the post-decrement beat_cnt != 0.
//  - A last flag of the wrong direction is ignored.
//  - Any beat arriving with beat_cnt already 0 pulses len_err.
//  Arbitration restarts in the IDLE cycle after done, so there is one idle cycle between bursts.
//  Outside XFER: app_wr_data=0, and all mN_wr_next/mN_rd_valid=0.
// TESTING
//  1. m0 write, len=4, ack after 2 cycles, 4 wr_next, last on 4th:
//     app_req 1 cycle after req; 4 m0_wr_next; m0_done; no len_err; grant 01->00.
//  2. m0 and m1 both request at reset exit:
//     m0 served first, m1 next (grant 01 then 10); repeating both requests alternates.
//  3. m1 read len=8, 8 rd_valid with data 0x1..0x8:
//     m1_rd_valid 8x, m0_rd_valid stays 0, m1_done on last.
//  4. m0 write len=4, controller asserts last after 3 wr_next:
//     len_err pulses with m0_done; FSM returns to IDLE.
//  5. m1 request len=0:
//     m1_ack and len_err pulse, app_req never asserts.
//  6. Assert reset_n=0 mid-XFER of 8-beat read:
//     all outputs 0 immediately; after release, m0 wins a tie.

Source files
------------

// File: rtl/sdrc_app_arbiter.sv
// Two-master round-robin arbiter and burst sequencer in front of the SDRAM
// controller application port. The grant is held for a whole burst, and the
// write-next and read-valid strobes are steered back to the owning master.
module sdrc_app_arbiter #(
  parameter int unsigned APP_AW = 26,
  parameter int unsigned APP_DW = 32,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic [APP_AW-1:0] m0_addr,
  input  logic [LEN_W-1:0]  m0_len,
  input  logic              m0_wr_n,
  input  logic [APP_DW-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic              m0_wr_next,
  output logic              m0_rd_valid,
  output logic              m0_done,
  input  logic              m1_req,
  input  logic [APP_AW-1:0] m1_addr,
  input  logic [LEN_W-1:0]  m1_len,
  input  logic              m1_wr_n,
  input  logic [APP_DW-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic              m1_wr_next,
  output logic              m1_rd_valid,
  output logic              m1_done,
  output logic              app_req,
  output logic [APP_AW-1:0] app_req_addr,
  output logic [LEN_W-1:0]  app_req_len,
  output logic              app_req_wr_n,
  input  logic              app_req_ack,
  output logic [APP_DW-1:0] app_wr_data,
  input  logic              app_wr_next,
  input  logic              app_last_wr,
  input  logic              app_rd_valid,
  input  logic              app_last_rd,
  input  logic [APP_DW-1:0] app_rd_data,
  output logic [1:0]        grant,
  output logic              len_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              rr_q, rr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              wr_n_q, wr_n_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        done_q, done_d;
  logic              len_err_q, len_err_d;

  logic [1:0]        req_v;
  logic              win;
  logic [LEN_W-1:0]  win_len;
  logic              beat;
  logic              last;
  logic              in_xfer;

  // Read data is wired straight to both masters outside this block.
  logic unused_rd_data;
  assign unused_rd_data = ^app_rd_data;

  // Next-state logic: arbitration, request handshake and beat accounting.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wr_n_d    = wr_n_q;
    ack_d     = '0;
    done_d    = '0;
    len_err_d = 1'b0;
    win       = 1'b0;
    win_len   = '0;
    beat      = 1'b0;
    last      = 1'b0;
    // A request whose ack is pulsing right now is being withdrawn; ignore it.
    req_v     = {m1_req & ~ack_q[1], m0_req & ~ack_q[0]};
    case (state_q)
      ST_IDLE: begin
        if (req_v != 2'b00) begin
          win     = (req_v == 2'b11) ? rr_q : req_v[1];
          win_len = win ? m1_len : m0_len;
          if (win_len == '0) begin
            ack_d[win] = 1'b1;
            len_err_d  = 1'b1;
            rr_d       = ~rr_q;
          end else begin
            state_d = ST_REQ;
            grant_d = win ? 2'b10 : 2'b01;
            cnt_d   = win_len;
            len_d   = win_len;
            addr_d  = win ? m1_addr : m0_addr;
            wr_n_d  = win ? m1_wr_n : m0_wr_n;
          end
        end
      end
      ST_REQ: begin
        if (app_req_ack) begin
          state_d             = ST_XFER;
          ack_d[grant_q[1]]   = 1'b1;
        end
      end
      ST_XFER: begin
        beat = wr_n_q ? app_rd_valid : app_wr_next;
        last = wr_n_q ? app_last_rd  : app_last_wr;
        if (beat) begin
          if (cnt_q == '0) begin
            len_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q - LEN_ONE;
          end
        end
        if (last) begin
          state_d            = ST_IDLE;
          grant_d            = '0;
          done_d[grant_q[1]] = 1'b1;
          rr_d               = ~grant_q[1];
          if (cnt_d != '0) begin
            len_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      wr_n_q    <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wr_n_q    <= wr_n_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
    end
  end

  assign in_xfer      = (state_q == ST_XFER);
  assign app_req      = (state_q == ST_REQ);
  assign app_req_addr = addr_q;
  assign app_req_len  = len_q;
  assign app_req_wr_n = wr_n_q;
  assign grant        = grant_q;
  assign len_err      = len_err_q;
  assign m0_ack       = ack_q[0];
  assign m1_ack       = ack_q[1];
  assign m0_done      = done_q[0];
  assign m1_done      = done_q[1];

  assign app_wr_data  = in_xfer ? (grant_q[1] ? m1_wr_data : m0_wr_data) : '0;
  assign m0_wr_next   = in_xfer & grant_q[0] & app_wr_next;
  assign m1_wr_next   = in_xfer & grant_q[1] & app_wr_next;
  assign m0_rd_valid  = in_xfer & grant_q[0] & app_rd_valid;
  assign m1_rd_valid  = in_xfer & grant_q[1] & app_rd_valid;

endmodule

// File: tb/tb_sdrc_app_arbiter.sv
// Directed self-checking bench for sdrc_app_arbiter.
module tb_sdrc_app_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [25:0] m0_addr = 26'h100, m1_addr = 26'h2000;
  logic [8:0]  m0_len = '0, m1_len = '0;
  logic        m0_wr_n = 1'b0, m1_wr_n = 1'b0;
  logic [31:0] m0_wr_data = 32'hA0A0_0000, m1_wr_data = 32'hB1B1_0000;
  logic        m0_ack, m0_wr_next, m0_rd_valid, m0_done;
  logic        m1_ack, m1_wr_next, m1_rd_valid, m1_done;
  logic        app_req;
  logic [25:0] app_req_addr;
  logic [8:0]  app_req_len;
  logic        app_req_wr_n;
  logic        app_req_ack = 1'b0;
  logic [31:0] app_wr_data;
  logic        app_wr_next = 1'b0, app_last_wr = 1'b0;
  logic        app_rd_valid = 1'b0, app_last_rd = 1'b0;
  logic [31:0] app_rd_data = '0;
  logic [1:0]  grant;
  logic        len_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sdrc_app_arbiter #(.APP_AW(26), .APP_DW(32), .LEN_W(9)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_len(m0_len), .m0_wr_n(m0_wr_n),
    .m0_wr_data(m0_wr_data), .m0_ack(m0_ack), .m0_wr_next(m0_wr_next),
    .m0_rd_valid(m0_rd_valid), .m0_done(m0_done),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_len(m1_len), .m1_wr_n(m1_wr_n),
    .m1_wr_data(m1_wr_data), .m1_ack(m1_ack), .m1_wr_next(m1_wr_next),
    .m1_rd_valid(m1_rd_valid), .m1_done(m1_done),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
    .app_wr_data(app_wr_data), .app_wr_next(app_wr_next), .app_last_wr(app_last_wr),
    .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd), .app_rd_data(app_rd_data),
    .grant(grant), .len_err(len_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"},
          {20'd0, m0_ack, m0_wr_next, m0_rd_valid, m0_done, m1_ack, m1_wr_next,
           m1_rd_valid, m1_done, app_req, app_req_wr_n, len_err, 1'b0}, 32'd0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_wdata"}, app_wr_data, 0);
    check({tag, "_addr"}, app_req_addr, 0);
    check({tag, "_len"}, app_req_len, 0);
  endtask

  // Serve one burst for master m; the request(s) must already be driven while IDLE.
  task automatic serve(input int m, input logic [8:0] len, input logic wr_n,
                       input int ack_dly, input int nbeats, input logic exp_err);
    logic [1:0] g;
    logic own, oth;
    g = (m == 1) ? 2'b10 : 2'b01;
    tick;
    check("app_req", app_req, 1);
    check("grant", grant, g);
    check("req_addr", app_req_addr, (m == 1) ? m1_addr : m0_addr);
    check("req_len", app_req_len, len);
    check("req_wr_n", app_req_wr_n, wr_n);
    check("wdata_req", app_wr_data, 0);
    for (int i = 1; i < ack_dly; i++) begin
      tick;
      check("req_hold", app_req, 1);
      check("len_hold", app_req_len, len);
    end
    app_req_ack = 1'b1;
    tick;
    app_req_ack = 1'b0;
    check("ack", (m == 1) ? m1_ack : m0_ack, 1);
    check("ack_other", (m == 1) ? m0_ack : m1_ack, 0);
    check("req_drop", app_req, 0);
    if (m == 1) m1_req = 1'b0; else m0_req = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (wr_n) begin
        app_rd_valid = 1'b1;
        app_rd_data  = i + 1;
        app_last_rd  = (i == nbeats - 1);
      end else begin
        app_wr_next  = 1'b1;
        app_last_wr  = (i == nbeats - 1);
      end
      #1;
      if (wr_n) begin
        own = (m == 1) ? m1_rd_valid : m0_rd_valid;
        oth = (m == 1) ? m0_rd_valid : m1_rd_valid;
      end else begin
        own = (m == 1) ? m1_wr_next : m0_wr_next;
        oth = (m == 1) ? m0_wr_next : m1_wr_next;
        check("wdata", app_wr_data, (m == 1) ? m1_wr_data : m0_wr_data);
      end
      check("beat_owner", own, 1);
      check("beat_other", oth, 0);
      tick;
      app_rd_valid = 1'b0; app_last_rd = 1'b0;
      app_wr_next  = 1'b0; app_last_wr = 1'b0;
      if (i != nbeats - 1) check("done_early", (m == 1) ? m1_done : m0_done, 0);
    end
    check("done", (m == 1) ? m1_done : m0_done, 1);
    check("done_other", (m == 1) ? m0_done : m1_done, 0);
    check("len_err", len_err, exp_err);
    check("grant_clr", grant, 0);
  endtask

  initial begin
    // Reset state.
    #12;
    check_all_zero("reset");
    tick;
    reset_n = 1'b1;

    // 1: m0 write len=4, ack after 2 cycles.
    m0_len = 9'd4; m0_wr_n = 1'b0; m0_req = 1'b1;
    #1;
    check("t1_no_early_req", app_req, 0);
    serve(0, 9'd4, 1'b0, 2, 4, 1'b0);
    tick;
    check("t1_done_pulse", m0_done, 0);
    check("t1_no_err", len_err, 0);

    // 2: both request at reset exit; alternation.
    reset_n = 1'b0;
    m0_len = 9'd2; m0_wr_n = 1'b0; m0_req = 1'b1;
    m1_len = 9'd2; m1_wr_n = 1'b1; m1_req = 1'b1;
    tick;
    reset_n = 1'b1;
    serve(0, 9'd2, 1'b0, 1, 2, 1'b0);
    m0_req = 1'b1;
    serve(1, 9'd2, 1'b1, 1, 2, 1'b0);
    m1_req = 1'b1;
    serve(0, 9'd2, 1'b0, 1, 2, 1'b0);
    serve(1, 9'd2, 1'b1, 1, 2, 1'b0);

    // 3: m1 read len=8.
    m1_len = 9'd8; m1_wr_n = 1'b1; m1_req = 1'b1;
    serve(1, 9'd8, 1'b1, 1, 8, 1'b0);

    // 4: m0 write len=4, last after 3 beats.
    m0_len = 9'd4; m0_wr_n = 1'b0; m0_req = 1'b1;
    serve(0, 9'd4, 1'b0, 1, 3, 1'b1);

    // 5: m1 len=0, then a tie resolved by the toggled pointer.
    m1_len = 9'd0; m1_wr_n = 1'b0; m1_req = 1'b1;
    tick;
    check("t5_ack", m1_ack, 1);
    check("t5_len_err", len_err, 1);
    check("t5_no_req", app_req, 0);
    check("t5_grant", grant, 0);
    m1_req = 1'b0;
    tick;
    check("t5_ack_pulse", m1_ack, 0);
    check("t5_err_pulse", len_err, 0);
    check("t5_still_no_req", app_req, 0);
    m0_len = 9'd1; m0_wr_n = 1'b0; m0_req = 1'b1;
    m1_len = 9'd1; m1_wr_n = 1'b0; m1_req = 1'b1;
    serve(0, 9'd1, 1'b0, 1, 1, 1'b0);
    serve(1, 9'd1, 1'b0, 1, 1, 1'b0);

    // 6: reset mid-XFER of an 8-beat read.
    m1_len = 9'd8; m1_wr_n = 1'b1; m1_req = 1'b1;
    tick;
    check("t6_req", app_req, 1);
    app_req_ack = 1'b1;
    tick;
    app_req_ack = 1'b0;
    m1_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      app_rd_valid = 1'b1;
      tick;
    end
    #1;
    check("t6_rd_valid", m1_rd_valid, 1);
    check("t6_grant", grant, 2'b10);
    reset_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    app_rd_valid = 1'b0;
    m0_len = 9'd2; m0_wr_n = 1'b0; m0_req = 1'b1;
    m1_len = 9'd2; m1_wr_n = 1'b0; m1_req = 1'b1;
    tick;
    check("t6_no_done", m1_done, 0);
    tick;
    reset_n = 1'b1;
    tick;
    check("t6_tie_grant", grant, 2'b01);
    check("t6_tie_req", app_req, 1);
    check("t6_no_done_after", m1_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
